// File: rtl/imem_arb_pkg.sv
// Shared types and default widths for the two-port instruction-memory read arbiter.
package imem_arb_pkg;

  localparam int unsigned AddrWidthDef = 11;
  localparam int unsigned DataWidthDef = 32;

  typedef logic port_id_t;

  localparam port_id_t Port0 = 1'b0;
  localparam port_id_t Port1 = 1'b1;

  function automatic port_id_t other_port(port_id_t p);
    return ~p;
  endfunction

endpackage

// File: rtl/imem_rsp_buf.sv
// One-entry response hold buffer: passes memory data straight through, or keeps it
// stable while the consumer stalls.
module imem_rsp_buf #(
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  inflight_i,
  input  logic                  rsp_ready_i,
  input  logic [DATA_WIDTH-1:0] mem_dout_i,
  output logic                  rsp_valid_o,
  output logic [DATA_WIDTH-1:0] rsp_data_o,
  output logic                  full_o
);

  logic                  full_q, full_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;

  always_comb begin
    full_d = full_q;
    data_d = data_q;
    if (full_q) begin
      if (rsp_ready_i) full_d = 1'b0;
    end else if (inflight_i && !rsp_ready_i) begin
      // Read data is only on mem_dout for one cycle; park it until accepted.
      full_d = 1'b1;
      data_d = mem_dout_i;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      full_q <= 1'b0;
      data_q <= '0;
    end else begin
      full_q <= full_d;
      data_q <= data_d;
    end
  end

  assign rsp_valid_o = full_q | inflight_i;
  assign rsp_data_o  = full_q ? data_q : mem_dout_i;
  assign full_o      = full_q;

endmodule

// File: rtl/imem_arbiter.sv
// Round-robin arbiter sharing one synchronous-read instruction memory between the
// fetch port (0) and the loader/debug port (1).
module imem_arbiter
  import imem_arb_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = AddrWidthDef,
  parameter int unsigned DATA_WIDTH = DataWidthDef
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req0_valid,
  output logic                  req0_ready,
  input  logic [ADDR_WIDTH-1:0] req0_addr,
  output logic                  rsp0_valid,
  input  logic                  rsp0_ready,
  output logic [DATA_WIDTH-1:0] rsp0_data,
  input  logic                  req1_valid,
  output logic                  req1_ready,
  input  logic [ADDR_WIDTH-1:0] req1_addr,
  output logic                  rsp1_valid,
  input  logic                  rsp1_ready,
  output logic [DATA_WIDTH-1:0] rsp1_data,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  input  logic [DATA_WIDTH-1:0] mem_dout
);

  port_id_t   ptr_q, ptr_d;
  port_id_t   issue_id_q, issue_id_d;
  logic       issue_vld_q, issue_vld_d;
  logic [1:0] full, inflight, elig, gnt;

  assign inflight[0] = issue_vld_q && (issue_id_q == Port0);
  assign inflight[1] = issue_vld_q && (issue_id_q == Port1);

  // A port may take a new read only if its previous response leaves this cycle.
  assign elig[0] = req0_valid && !full[0] && (!inflight[0] || rsp0_ready);
  assign elig[1] = req1_valid && !full[1] && (!inflight[1] || rsp1_ready);

  always_comb begin
    gnt         = 2'b00;
    ptr_d       = ptr_q;
    issue_vld_d = 1'b0;
    issue_id_d  = issue_id_q;
    mem_addr    = '0;
    if (&elig) begin
      gnt = (ptr_q == Port0) ? 2'b01 : 2'b10;
    end else begin
      gnt = elig;
    end
    if (gnt[0]) begin
      mem_addr = req0_addr;
    end else if (gnt[1]) begin
      mem_addr = req1_addr;
    end
    if (|gnt) begin
      ptr_d       = other_port(ptr_q);
      issue_vld_d = 1'b1;
      issue_id_d  = gnt[1] ? Port1 : Port0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q       <= Port0;
      issue_vld_q <= 1'b0;
      issue_id_q  <= Port0;
    end else begin
      ptr_q       <= ptr_d;
      issue_vld_q <= issue_vld_d;
      issue_id_q  <= issue_id_d;
    end
  end

  assign req0_ready = gnt[0];
  assign req1_ready = gnt[1];

  imem_rsp_buf #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_buf0 (
    .clk        (clk),
    .rst_n      (rst_n),
    .inflight_i (inflight[0]),
    .rsp_ready_i(rsp0_ready),
    .mem_dout_i (mem_dout),
    .rsp_valid_o(rsp0_valid),
    .rsp_data_o (rsp0_data),
    .full_o     (full[0])
  );

  imem_rsp_buf #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_buf1 (
    .clk        (clk),
    .rst_n      (rst_n),
    .inflight_i (inflight[1]),
    .rsp_ready_i(rsp1_ready),
    .mem_dout_i (mem_dout),
    .rsp_valid_o(rsp1_valid),
    .rsp_data_o (rsp1_data),
    .full_o     (full[1])
  );

endmodule

// File: tb/tb_imem_arbiter.sv
// Directed bench for imem_arbiter with a transaction-level reference model checked every cycle.
module tb_imem_arbiter;

  localparam int AW = 11;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          req0_valid, req0_ready, rsp0_valid, rsp0_ready;
  logic          req1_valid, req1_ready, rsp1_valid, rsp1_ready;
  logic [AW-1:0] req0_addr, req1_addr, mem_addr;
  logic [DW-1:0] rsp0_data, rsp1_data, mem_dout;

  int errors = 0;
  int checks = 0;

  imem_arbiter #(
    .ADDR_WIDTH(AW),
    .DATA_WIDTH(DW)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req0_valid(req0_valid),
    .req0_ready(req0_ready),
    .req0_addr (req0_addr),
    .rsp0_valid(rsp0_valid),
    .rsp0_ready(rsp0_ready),
    .rsp0_data (rsp0_data),
    .req1_valid(req1_valid),
    .req1_ready(req1_ready),
    .req1_addr (req1_addr),
    .rsp1_valid(rsp1_valid),
    .rsp1_ready(rsp1_ready),
    .rsp1_data (rsp1_data),
    .mem_addr  (mem_addr),
    .mem_dout  (mem_dout)
  );

  always #5 clk = ~clk;

  // RAM contents: word i holds "addi x1, x0, i".
  function automatic logic [DW-1:0] ram_f(input logic [AW-1:0] a);
    return (32'(a) << 20) | 32'h0000_0093;
  endfunction

  always @(posedge clk) mem_dout <= ram_f(mem_addr);

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: per-port outstanding response (pending/held) plus a pointer.
  int            m_ptr;
  logic          pv[2];
  logic          ph[2];
  logic [DW-1:0] pd[2];

  always @(negedge clk) begin
    logic          vin[2], rdy[2], elig[2];
    logic [AW-1:0] ad[2];
    logic [AW-1:0] exp_addr;
    int            g;
    if (!rst_n) begin
      m_ptr = 0;
      for (int n = 0; n < 2; n++) begin
        pv[n] = 1'b0;
        ph[n] = 1'b0;
      end
    end
    vin[0] = req0_valid; vin[1] = req1_valid;
    rdy[0] = rsp0_ready; rdy[1] = rsp1_ready;
    ad[0]  = req0_addr;  ad[1]  = req1_addr;
    for (int n = 0; n < 2; n++) elig[n] = vin[n] && (!pv[n] || (rdy[n] && !ph[n]));
    if (elig[0] && elig[1]) g = m_ptr;
    else if (elig[0]) g = 0;
    else if (elig[1]) g = 1;
    else g = -1;
    exp_addr = (g < 0) ? '0 : ad[g];
    chk("m_req0_ready", 32'(req0_ready), 32'(g == 0));
    chk("m_req1_ready", 32'(req1_ready), 32'(g == 1));
    chk("m_mem_addr", 32'(mem_addr), 32'(exp_addr));
    chk("m_rsp0_valid", 32'(rsp0_valid), 32'(pv[0]));
    chk("m_rsp1_valid", 32'(rsp1_valid), 32'(pv[1]));
    if (pv[0]) chk("m_rsp0_data", rsp0_data, pd[0]);
    if (pv[1]) chk("m_rsp1_data", rsp1_data, pd[1]);
    if (rst_n) begin
      for (int n = 0; n < 2; n++) begin
        if (pv[n] && rdy[n]) pv[n] = 1'b0;
        else if (pv[n]) ph[n] = 1'b1;
      end
      if (g >= 0) begin
        pv[g] = 1'b1;
        ph[g] = 1'b0;
        pd[g] = ram_f(exp_addr);
        m_ptr = 1 - m_ptr;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    req0_valid = 1'b0; req1_valid = 1'b0;
    req0_addr  = '0;   req1_addr  = '0;
    rsp0_ready = 1'b1; rsp1_ready = 1'b1;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst_n = 1'b0;
    step();
    step();
    rst_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    idle_inputs();
    rst_n = 1'b0;
    step();
    step();
    rst_n = 1'b1;

    // Idle: nothing requested, nothing granted or returned.
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("idle_addr", 32'(mem_addr), 32'h0);
      chk("idle_rdy", 32'({req0_ready, req1_ready}), 32'h0);
      chk("idle_rsp", 32'({rsp0_valid, rsp1_valid}), 32'h0);
      step();
    end

    // Single port read of address 5.
    req0_valid = 1'b1; req0_addr = 11'd5;
    @(negedge clk);
    chk("single_rdy", 32'(req0_ready), 32'h1);
    chk("single_addr", 32'(mem_addr), 32'd5);
    step();
    req0_valid = 1'b0;
    @(negedge clk);
    chk("single_rsp_v", 32'(rsp0_valid), 32'h1);
    chk("single_rsp_d", rsp0_data, 32'h0050_0093);
    chk("single_rsp1", 32'(rsp1_valid), 32'h0);
    step();

    // Contention from reset: grants 0,1,0,1.
    do_reset();
    req0_valid = 1'b1; req0_addr = 11'd1;
    req1_valid = 1'b1; req1_addr = 11'd2;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("cont_g0", 32'(req0_ready), (i % 2 == 0) ? 32'h1 : 32'h0);
      chk("cont_g1", 32'(req1_ready), (i % 2 == 1) ? 32'h1 : 32'h0);
      if (i % 2 == 1) chk("cont_rsp0", rsp0_data, 32'h0010_0093);
      if (i == 2) chk("cont_rsp1", rsp1_data, 32'h0020_0093);
      step();
    end
    idle_inputs();
    @(negedge clk);
    chk("cont_last", rsp1_data, 32'h0020_0093);
    step();

    // Backpressure on port 0 while port 1 keeps being served.
    req0_valid = 1'b1; req0_addr = 11'd7;
    @(negedge clk);
    chk("bp_grant", 32'(req0_ready), 32'h1);
    step();
    rsp0_ready = 1'b0; req0_addr = 11'd8;
    req1_valid = 1'b1; req1_addr = 11'd3;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("bp_v", 32'(rsp0_valid), 32'h1);
      chk("bp_data", rsp0_data, 32'h0070_0093);
      chk("bp_rdy0", 32'(req0_ready), 32'h0);
      chk("bp_rdy1", 32'(req1_ready), 32'h1);
      step();
      req1_addr = AW'(4 + i);
    end
    rsp0_ready = 1'b1; req0_valid = 1'b0; req1_valid = 1'b0;
    @(negedge clk);
    chk("bp_drain", rsp0_data, 32'h0070_0093);
    step();
    step();
    step();

    // Streaming 16 back-to-back reads on port 0.
    for (int i = 0; i <= 16; i++) begin
      if (i < 16) begin
        req0_valid = 1'b1; req0_addr = AW'(i);
      end else begin
        req0_valid = 1'b0;
      end
      @(negedge clk);
      if (i < 16) chk("stream_rdy", 32'(req0_ready), 32'h1);
      if (i > 0) begin
        chk("stream_v", 32'(rsp0_valid), 32'h1);
        chk("stream_d", rsp0_data, (32'(i - 1) << 20) | 32'h93);
      end
      step();
    end
    step();

    // Reset pulsed the cycle after a grant discards the response.
    req1_valid = 1'b1; req1_addr = 11'd9;
    @(negedge clk);
    chk("rst_grant", 32'(req1_ready), 32'h1);
    step();
    req1_valid = 1'b0; rst_n = 1'b0;
    @(negedge clk);
    chk("rst_rsp1", 32'(rsp1_valid), 32'h0);
    step();
    rst_n = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk("rst_post", 32'({rsp0_valid, rsp1_valid}), 32'h0);
      step();
    end
    req0_valid = 1'b1; req0_addr = 11'd2;
    req1_valid = 1'b1; req1_addr = 11'd3;
    @(negedge clk);
    chk("rst_ptr0", 32'(req0_ready), 32'h1);
    chk("rst_ptr1", 32'(req1_ready), 32'h0);
    step();
    idle_inputs();
    step();

    // Idle cycles leave the pointer at port 1.
    for (int i = 0; i < 3; i++) step();
    req0_valid = 1'b1; req0_addr = 11'd4;
    req1_valid = 1'b1; req1_addr = 11'd6;
    @(negedge clk);
    chk("idle_ptr1", 32'(req1_ready), 32'h1);
    chk("idle_ptr0", 32'(req0_ready), 32'h0);
    step();
    idle_inputs();
    step();
    step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/imem_arbiter.md
IMEM_ARBITER -- requirements
Module: imem_arbiter

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 11, word address width of the instruction memory.
REQ-002 SHALL have parameter DATA_WIDTH, default 32, instruction word width.
REQ-003 SHALL have port clk  input  1  single clock; all state on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have ports req0_valid  input  1 / req0_ready  output  1 / req0_addr  input  ADDR_WIDTH  fetch-port read request.
REQ-006 SHALL have ports rsp0_valid  output  1 / rsp0_ready  input  1 / rsp0_data  output  DATA_WIDTH  fetch-port read response.
REQ-007 SHALL have ports req1_*/rsp1_*, identical to port 0, as the loader/debug read port.
REQ-008 SHALL have port mem_addr  output  ADDR_WIDTH  address to the synchronous-read instruction memory.
REQ-009 SHALL have port mem_dout  input  DATA_WIDTH  memory data, valid one cycle after mem_addr is sampled.

Function
REQ-010 SHALL accept a request on port N when reqN_valid and reqN_ready are both high in the same cycle (a grant).
REQ-011 SHALL grant at most one port per cycle, round-robin: priority pointer flips to the other port after every grant; with one requester, that port wins regardless of pointer.
REQ-012 SHALL drive mem_addr combinationally with the granted port's address, and with 0 when no grant occurs.
REQ-013 SHALL make reqN_ready high only when port N wins arbitration, port N's hold buffer is empty, and no response of port N is in flight unless rspN_ready is high that cycle.
REQ-014 SHALL register in-flight state (issue valid, issue port ID) on each grant; read latency is exactly one cycle: grant in cycle T gives rspN_valid high in T+1 with rspN_data = mem_dout.
REQ-015 SHALL, if rspN_ready is low in T+1, capture mem_dout into port N's hold buffer and keep rspN_valid high with stable rspN_data until rspN_ready is high.
REQ-016 SHALL source rspN_data from the hold buffer when it is full, otherwise from mem_dout.
REQ-017 SHALL let a port sustain one grant per cycle when its rsp_ready is held high (full throughput).
REQ-018 SHALL never assert rsp0_valid and rsp1_valid from the same memory read; only the port whose ID was recorded receives data.
REQ-019 SHALL with both ports requesting continuously alternate grants 0,1,0,1,... starting from the pointer value.
REQ-020 SHALL not change the priority pointer in a cycle with no grant.

Reset
REQ-021 SHALL, on rst_n low (asynchronous), clear in-flight valid, both hold buffers, rspN_valid, and set the priority pointer to port 0; req0_ready, req1_ready and mem_addr follow REQ-012/013 from this state.
REQ-022 SHALL discard any in-flight or held response when reset asserts mid-operation; no response appears after reset release without a new grant.
REQ-023 SHALL reset hold-buffer data to 0.

Structure
REQ-024 SHALL take port-ID typedef (1 bit) and default ADDR_WIDTH/DATA_WIDTH constants from shared package imem_arb_pkg.
REQ-025 SHALL implement each port's response hold buffer as sub-module imem_rsp_buf, instantiated twice.
REQ-026 SHALL be 120-400 lines of RTL total, with no memory array inside the arbiter.

Verification
REQ-027 SHALL cover single port: req0 addr 5 accepted, RAM[5]=0x00500093 -> rsp0_valid next cycle, data 0x00500093, rsp1_valid stays 0.
REQ-028 SHALL cover contention: both ports valid 4 cycles from reset, addrs 1 and 2 -> grants 0,1,0,1; responses alternate with correct data each cycle.
REQ-029 SHALL cover backpressure: rsp0_ready low 3 cycles after grant of addr 7 -> rsp0_data stable at RAM[7] for 3 cycles, req0_ready low, port 1 still granted.
REQ-030 SHALL cover streaming: port 0 addrs 0..15 back-to-back, rsp0_ready high -> 16 responses in 16 consecutive cycles, in order.
REQ-031 SHALL cover reset mid-operation: rst_n pulsed low the cycle after a grant -> no rsp valid after release, pointer at port 0.
REQ-032 SHALL cover idle: no requests -> mem_addr 0, all ready/valid outputs 0, pointer unchanged.
